// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Time-multiplexed scan controller for common-anode 7-seg digits
//            sharing one BCD decoder, with guard time and frame-aligned load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD_CYC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    lz_blank,
    input  logic                    en,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_start
);

    localparam int c_dw      = 4 * NUM_DIGITS;
    localparam int c_cnt_max = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_idx_w   = $clog2(NUM_DIGITS);

    localparam logic [c_cnt_w-1:0] c_scan_last  = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

    localparam logic [0:0] c_st_drive = 1'b0;
    localparam logic [0:0] c_st_guard = 1'b1;

    logic [0:0]            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_dw-1:0]       r_disp;
    logic [c_dw-1:0]       r_pend;
    logic                  r_pend_v;

    logic [0:0]            w_state_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic [c_idx_w-1:0]    w_idx_nxt;
    logic                  w_advance;
    logic                  w_frame_end;
    logic                  w_accept;
    logic [3:0]            w_code;
    logic [NUM_DIGITS-1:0] w_lz_mask;

    // ------------------------------------------------------------------
    // Scan FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_advance   = 1'b0;
        case (r_state)
            c_st_drive: begin
                if (r_cnt == c_scan_last) begin
                    w_cnt_nxt = '0;
                    if (GUARD_CYC == 0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_state_nxt = c_st_guard;
                    end
                end
            end
            default: begin
                if (r_cnt == c_guard_last) begin
                    w_cnt_nxt = '0;
                    w_advance = 1'b1;
                end
            end
        endcase
        if (w_advance) begin
            w_state_nxt = c_st_drive;
            w_idx_nxt   = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_drive;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Load handshake and frame-boundary commit
    // ------------------------------------------------------------------
    assign w_frame_end = w_advance && (r_idx == c_idx_last);
    assign load_ready  = !rst && !r_pend_v;
    assign w_accept    = load_valid && load_ready;

    // Accept requires !r_pend_v, so commit and accept never fire together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp   <= '1;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else begin
            if (w_frame_end && r_pend_v) begin
                r_disp   <= r_pend;
                r_pend_v <= 1'b0;
            end
            if (w_accept) begin
                r_pend   <= load_data;
                r_pend_v <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: digit k blankable when it and all higher nibbles
    // are zero; digit 0 always shows.
    // ------------------------------------------------------------------
    for (genvar gk = 0; gk < NUM_DIGITS; gk++) begin : g_lz
        if (gk == 0) begin : g_d0
            assign w_lz_mask[gk] = 1'b0;
        end else begin : g_dn
            assign w_lz_mask[gk] = (r_disp[c_dw-1:4*gk] == '0);
        end
    end

    assign w_code = r_disp[{r_idx, 2'b00} +: 4];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        digit_en_n = '1;
        bcd_out    = 4'hF;
        if (!rst && en && (r_state == c_st_drive)) begin
            digit_en_n[r_idx] = 1'b0;
            bcd_out           = (lz_blank && w_lz_mask[r_idx]) ? 4'hF : w_code;
        end
    end

    assign frame_start = !rst && (r_state == c_st_drive) && (r_idx == '0) && (r_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Scoreboard bench for seg7_scan_ctrl (4 digits, 4 drive + 1 guard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0;
    logic        lz_blank   = 1'b0;
    logic        en         = 1'b1;
    logic        load_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en_n;
    logic        frame_start;

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .GUARD_CYC  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .lz_blank    (lz_blank),
        .en          (en),
        .bcd_out     (bcd_out),
        .digit_en_n  (digit_en_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        int          t;
    } acc_t;

    acc_t        sb[$];
    int          cyc;
    logic [15:0] cur_disp;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [9:0]  obs;
    logic [9:0]  exp_v;

    function automatic logic [3:0] f_code(logic [15:0] v, int k, logic lz);
        logic [15:0] upper;
        upper = v >> (4 * k);
        if (lz && (k > 0) && (upper == 16'h0)) return 4'hF;
        return upper[3:0];
    endfunction

    // Expected {digit_en_n, bcd_out, frame_start, load_ready} from cycle position.
    function automatic logic [9:0] exp_vec();
        int         p    = cyc % 5;
        int         d    = (cyc % 20) / 5;
        logic [3:0] en_n = 4'hF;
        logic [3:0] code = 4'hF;
        if ((p < 4) && en) begin
            en_n = ~(4'b0001 << d);
            code = f_code(cur_disp, d, lz_blank);
        end
        return {en_n, code, (cyc % 20 == 0), (sb.size() == 0)};
    endfunction

    // Accepted loads enter the scoreboard; each leaves it at the first
    // frame start whose commit edge came strictly after the accept edge.
    task automatic advance_cycle();
        if (load_valid && (sb.size() == 0)) sb.push_back('{load_data, cyc});
        @(posedge clk);
        #1;
        cyc++;
        if ((cyc % 20 == 0) && (sb.size() > 0) && (sb[0].t <= cyc - 2)) begin
            cur_disp = sb[0].v;
            sb.pop_front();
        end
    endtask

    task automatic skip_to(int ph);
        while (cyc % 20 != ph) advance_cycle();
    endtask

    task automatic do_reset(string name);
        rst        = 1'b1;
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            obs = {digit_en_n, bcd_out, frame_start, load_ready};
            if (obs !== 10'b1111_1111_0_0) begin
                miscompares++;
                $display("FAIL %s_hold i=%0d got=%b exp=%b", name, i, obs, 10'b1111_1111_0_0);
            end
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        cyc      = 0;
        cur_disp = 16'hFFFF;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset("reset");
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_scan cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
        end
    endtask

    task automatic test_load_midframe();
        skip_to(7);
        load_data  = 16'h1234;
        load_valid = 1'b1;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL load_mid cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
            load_valid = 1'b0;
        end
    endtask

    task automatic test_boundary();
        skip_to(18);
        load_data  = 16'h5678;
        load_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL boundary_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
            load_valid = 1'b0;
        end
        skip_to(19);
        load_data  = 16'h9ABC;
        load_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL boundary_edge cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
            load_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        skip_to(3);
        load_data  = 16'h1111;
        load_valid = 1'b1;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
            load_data  = 16'h2222;
            load_valid = (i < 5);
        end
        load_data  = 16'h2222;
        load_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_reoffer cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
            load_valid = 1'b0;
        end
    endtask

    task automatic test_lz();
        skip_to(2);
        load_data  = 16'h0070;
        load_valid = 1'b1;
        advance_cycle();
        load_valid = 1'b0;
        skip_to(0);
        for (int i = 0; i < 40; i++) begin
            lz_blank = (i >= 20);
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL lz_0070 cyc=%0d lz=%0b got=%b exp=%b", cyc, lz_blank, obs, exp_v);
            end
            advance_cycle();
        end
        skip_to(2);
        load_data  = 16'h0000;
        load_valid = 1'b1;
        advance_cycle();
        load_valid = 1'b0;
        skip_to(0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL lz_0000 cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_en_and_reset();
        skip_to(3);
        for (int i = 0; i < 30; i++) begin
            en = (i >= 10);
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL en_gate cyc=%0d en=%0b got=%b exp=%b", cyc, en, obs, exp_v);
            end
            advance_cycle();
        end
        en = 1'b1;
        skip_to(5);
        load_data  = 16'h8888;
        load_valid = 1'b1;
        advance_cycle();
        load_valid = 1'b0;
        skip_to(11);
        do_reset("midframe_rst");
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            vectors++;
            obs   = {digit_en_n, bcd_out, frame_start, load_ready};
            exp_v = exp_vec();
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL after_rst cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            advance_cycle();
        end
    endtask

    initial begin
        cyc      = 0;
        cur_disp = 16'hFFFF;
        test_reset();
        test_load_midframe();
        test_boundary();
        test_back_to_back();
        test_lz();
        test_en_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
